pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline-stage buffer that carries one packed stage payload (an IF/ID, ID/EX, EX/MEM or MEM/WB struct flattened to `WIDTH` bits) between adjacent stages of the RISC-V pipeline. It adds four things a plain stage register lacks:
- a valid/ready handshake;
- hazard-unit hold and flush, with flush injecting a configurable bubble;
- an optional 2-entry skid mode that removes the combinational ready path;
- a saturating starvation counter for performance analysis.

## Interface
- `WIDTH`, default 64: payload width in bits (≥1).
- `SKID`, default 1: selects the buffer mode.
  - 0: single register; `in_ready` depends combinationally on `out_ready`.
  - 1: main plus skid entry; `in_ready` is registered-only.
- `BUBBLE_VAL`, default `'0`: `WIDTH`-bit payload loaded on reset and flush. For the control stages this encodes a NOP with all write-enable bits clear.
- `CNT_W`, default 16: width of the starvation counter.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream payload valid.
- `in_ready` out 1: buffer can accept this cycle.
- `in_data` in `WIDTH`: upstream payload.
- `out_valid` out 1: `out_data` valid to downstream.
- `out_ready` in 1: downstream accepts.
- `out_data` out `WIDTH`: payload of the main entry.
- `hold` in 1: hazard stall; freezes all contents.
- `flush` in 1: kill all held and incoming payloads (branch/jump redirect).
- `occupancy` out 2: entries held, 0..2 (0..1 when `SKID`=0).
- `starve_cnt` out `CNT_W`: saturating count of starved cycles.

## Operation
State:
- Main entry `M` (`m_valid`, `m_data`).
- Skid entry `S` (`s_valid`, `s_data`), present only when `SKID`=1.

Combinational outputs:
- `out_data` = `m_data`.
- `out_valid` = `m_valid` & !`hold` & !`reset`.
- `in_ready`:
  - `SKID`=1: !`s_valid` & !`hold` & !`flush` & !`reset`.
  - `SKID`=0: (!`m_valid` | `out_ready`) & !`hold` & !`flush` & !`reset`.

Transfers:
- `in_fire` = `in_valid` & `in_ready`.
- `out_fire` = `out_valid` & `out_ready`.

Priority per edge, highest first:
1. `reset`:
   - `m_valid`=`s_valid`=0.
   - `m_data`=`s_data`=`BUBBLE_VAL`.
   - `starve_cnt`=0.
2. `flush`:
   - `m_valid`=`s_valid`=0; `m_data`=`s_data`=`BUBBLE_VAL`.
   - Any `in_data` presented this cycle is discarded.
   - `starve_cnt` is not incremented.
3. `hold`: all entries unchanged. No fire occurs, because both `in_ready` and `out_valid` are low.
4. Normal operation, `SKID`=1:
   - M empty, or `out_fire`:
     - `S` valid: `M`←`S`, then `S`←`in_data` if `in_fire`, else `S` cleared.
     - `S` empty: `M`←`in_data` if `in_fire`, else `m_valid`←0.
   - M full, no `out_fire`, `in_fire`: `S`←`in_data`.
   - Order is strictly FIFO; no payload is dropped or duplicated.
5. Normal operation, `SKID`=0:
   - `in_fire`: `M`←`in_data`.
   - Else `out_fire`: `m_valid`←0.

Data rules:
- `m_data` keeps its last value when `m_valid` drops; only reset and flush load `BUBBLE_VAL`.
- `occupancy` = `m_valid` + `s_valid`.

Starvation counter:
- `starve_cnt` increments when `out_ready` & !`m_valid` & !`hold` & !`flush`.
- It saturates at 2^`CNT_W`−1, with no wrap.

## Timing
- Latency is 1 cycle: a payload accepted at edge N is on `out_data`, with `out_valid`=1, after edge N.
- Throughput is 1 payload per cycle while `out_ready`=1.
- `SKID`=1:
  - No combinational path from `out_ready` to `in_ready`.
  - At most one extra payload is absorbed after `out_ready` falls.
- `SKID`=0: combinational path `out_ready`→`in_ready`.
- Reset values:
  - `out_valid`=0, `in_ready`=0 while `reset` is high.
  - `in_ready`=1 in the first cycle after reset, absent `hold`/`flush`.
  - `out_data`=`BUBBLE_VAL`, `occupancy`=0, `starve_cnt`=0.
- Simultaneous events:
  - `flush`+`hold`: flush wins.
  - `flush`+`in_valid`: input is dropped and `in_ready` reads 0.
  - `reset` mid-transfer: all state is lost and no fire occurs on that edge.
- A `hold` spanning any number of cycles preserves `m_data`/`s_data` bit-exact.

## Test plan
- **Streaming** (`SKID`=1, `WIDTH`=64): push 0x1..0x8 back-to-back with `out_ready`=1.
  - Required: outputs 0x1..0x8, each one cycle after acceptance.
  - `occupancy` stays 1 and `starve_cnt` stays 0.
- **Skid absorb** (`SKID`=1): `out_ready`=0 while pushing 0xA, 0xB, 0xC.
  - Required: 0xA and 0xB accepted; `in_ready`=0 on the 0xC cycle; `occupancy`=2.
  - After raising `out_ready`: outputs 0xA, 0xB, then 0xC, in order.
- **Flush**: with `occupancy`=2, assert `flush` together with `in_valid` and 0xFF.
  - Required next cycle: `out_valid`=0, `occupancy`=0, `out_data`=`BUBBLE_VAL`.
  - 0xFF never appears on the output.
- **Hold**: hold M=0x55 for 5 cycles with `in_valid`=1 and `out_ready`=1.
  - Required throughout: `in_ready`=0, `out_valid`=0, `m_data`=0x55, `starve_cnt` unchanged.
  - After release: 0x55 is output.
- **`SKID`=0 comb path**: M full, toggle `out_ready`.
  - Required: `in_ready` follows `out_ready` in the same cycle.
  - Simultaneous in/out fire replaces M with the new payload at full throughput.
- **Saturation and reset** (`CNT_W`=3): `out_ready`=1 with M empty for 10 cycles.
  - Required: `starve_cnt` reaches 7 and holds.
  - A mid-run `reset` zeroes the counter and outputs on the next edge.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: valid/ready handshake, hazard hold/flush with
// bubble injection, optional 2-entry skid mode and a saturating starvation counter.
module pipe_stage_buf #(
  parameter int unsigned      WIDTH      = 64,
  parameter int unsigned      SKID       = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] starve_cnt
);

  logic             m_valid;
  logic             m_valid_d;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_data_d;
  logic             s_valid;
  logic             in_fire;
  logic             out_fire;

  assign out_data  = m_data;
  assign out_valid = m_valid & ~hold & ~reset;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = 2'(m_valid) + 2'(s_valid);

  generate
    if (SKID != 0) begin : g_skid
      logic             s_valid_d;
      logic [WIDTH-1:0] s_data;
      logic [WIDTH-1:0] s_data_d;

      // Ready looks only at registered skid state, breaking the out_ready path.
      assign in_ready = ~s_valid & ~hold & ~flush & ~reset;

      always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        m_valid_d = m_valid;
        m_data_d  = m_data;
        s_valid_d = s_valid;
        s_data_d  = s_data;
        if (flush) begin
          m_valid_d = 1'b0;
          m_data_d  = BUBBLE_VAL;
          s_valid_d = 1'b0;
          s_data_d  = BUBBLE_VAL;
        end else if (!hold) begin
          if (!m_valid || out_fire) begin
            if (s_valid) begin
              m_valid_d = 1'b1;
              m_data_d  = s_data;
              s_valid_d = in_fire;
              if (in_fire) s_data_d = in_data;
            end else if (in_fire) begin
              m_valid_d = 1'b1;
              m_data_d  = in_data;
            end else begin
              m_valid_d = 1'b0;
            end
          end else if (in_fire) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          s_valid <= 1'b0;
          s_data  <= BUBBLE_VAL;
        end else begin
          s_valid <= s_valid_d;
          s_data  <= s_data_d;
        end
      end
    end else begin : g_single
      assign s_valid  = 1'b0;
      assign in_ready = (~m_valid | out_ready) & ~hold & ~flush & ~reset;

      always_comb begin
        m_valid_d = m_valid;
        m_data_d  = m_data;
        if (flush) begin
          m_valid_d = 1'b0;
          m_data_d  = BUBBLE_VAL;
        end else if (!hold) begin
          if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
          end else if (out_fire) begin
            m_valid_d = 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    // NOTE: the payload is reset as well, since BUBBLE_VAL must be visible on out_data.
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= BUBBLE_VAL;
    end else begin
      m_valid <= m_valid_d;
      m_data  <= m_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (out_ready && !m_valid && !hold && !flush && (starve_cnt != {CNT_W{1'b1}})) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (skid, single, 3-bit counter) share stimulus
// and are compared against a queue-based model, plus a directed vector table.
module tb_pipe_stage_buf;

  localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;

  logic        clk;
  logic        reset, in_valid, out_ready, hold, flush;
  logic [63:0] in_data;

  logic        ir1, ov1, ir0, ov0, irs, ovs;
  logic [63:0] od1, od0, ods;
  logic [1:0]  occ1, occ0, occs;
  logic [15:0] cnt1, cnt0;
  logic [2:0]  cnts;

  pipe_stage_buf #(.WIDTH(64), .SKID(1), .BUBBLE_VAL(BUB), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .hold(hold), .flush(flush),
    .occupancy(occ1), .starve_cnt(cnt1));

  pipe_stage_buf #(.WIDTH(64), .SKID(0), .BUBBLE_VAL(BUB), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .hold(hold), .flush(flush),
    .occupancy(occ0), .starve_cnt(cnt0));

  pipe_stage_buf #(.WIDTH(64), .SKID(1), .BUBBLE_VAL(BUB), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(irs), .in_data(in_data),
    .out_valid(ovs), .out_ready(out_ready), .out_data(ods), .hold(hold), .flush(flush),
    .occupancy(occs), .starve_cnt(cnts));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: each buffer is a bounded FIFO; out_data shows the head,
  // or the last payload that left (bubble after reset/flush).
  logic [63:0] q1[$];
  logic [63:0] q0[$];
  logic [63:0] last1 = BUB;
  logic [63:0] last0 = BUB;
  int c1 = 0, c0 = 0, cs = 0;
  bit model_en = 1'b0;

  task automatic model_check();
    bit e_ir1, e_ir0;
    e_ir1 = !reset && !hold && !flush && (q1.size() < 2);
    e_ir0 = !reset && !hold && !flush && ((q0.size() == 0) || out_ready);
    check("skid.in_ready",   64'(ir1),  64'(e_ir1));
    check("skid.out_valid",  64'(ov1),  64'(!reset && !hold && q1.size() > 0));
    check("skid.out_data",   od1,       (q1.size() > 0) ? q1[0] : last1);
    check("skid.occupancy",  64'(occ1), 64'(q1.size()));
    check("skid.starve_cnt", 64'(cnt1), 64'(c1));
    check("single.in_ready",   64'(ir0),  64'(e_ir0));
    check("single.out_valid",  64'(ov0),  64'(!reset && !hold && q0.size() > 0));
    check("single.out_data",   od0,       (q0.size() > 0) ? q0[0] : last0);
    check("single.occupancy",  64'(occ0), 64'(q0.size()));
    check("single.starve_cnt", 64'(cnt0), 64'(c0));
    check("sat.in_ready",   64'(irs),  64'(e_ir1));
    check("sat.out_data",   ods,       (q1.size() > 0) ? q1[0] : last1);
    check("sat.starve_cnt", 64'(cnts), 64'(cs));
  endtask

  task automatic model_step();
    bit inf1, outf1, inf0, outf0;
    if (reset) begin
      q1.delete(); q0.delete();
      last1 = BUB; last0 = BUB;
      c1 = 0; c0 = 0; cs = 0;
    end else if (flush) begin
      q1.delete(); q0.delete();
      last1 = BUB; last0 = BUB;
    end else if (!hold) begin
      if (out_ready && q1.size() == 0) begin
        if (c1 < 65535) c1++;
        if (cs < 7) cs++;
      end
      if (out_ready && q0.size() == 0 && c0 < 65535) c0++;
      inf1  = in_valid && (q1.size() < 2);
      outf1 = out_ready && (q1.size() > 0);
      inf0  = in_valid && ((q0.size() == 0) || out_ready);
      outf0 = out_ready && (q0.size() > 0);
      if (outf1) last1 = q1.pop_front();
      if (inf1) q1.push_back(in_data);
      if (outf0) last0 = q0.pop_front();
      if (inf0) q0.push_back(in_data);
    end
  endtask

  // Inputs are already driven (posedge+1); compare away from the edge, then advance.
  task automatic cycle();
    #2;
    if (model_en) model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic h, input logic iv,
                       input logic [63:0] d, input logic o);
    reset = r; flush = f; hold = h; in_valid = iv; in_data = d; out_ready = o;
  endtask

  typedef struct {
    logic        rst, fl, hd, iv;
    logic [63:0] d;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [63:0] e_od;
    logic [1:0]  e_occ;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic fl, input logic hd, input logic iv,
                             input logic [63:0] d, input logic o, input logic e_ir,
                             input logic e_ov, input logic [63:0] e_od, input logic [1:0] e_occ,
                             input logic [15:0] e_cnt);
    vec_t r;
    r.rst = rst; r.fl = fl; r.hd = hd; r.iv = iv; r.d = d; r.ordy = o;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.e_occ = e_occ; r.e_cnt = e_cnt;
    return r;
  endfunction

  initial begin
    // Expected values describe the skid instance in the cycle before each edge.
    tbl.push_back(v(1, 0, 0, 0, 64'h0,  0, 0, 0, BUB,    0, 0));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  0, 1, 0, BUB,    0, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'h1,  0, 1, 0, BUB,    0, 0));
    for (int k = 2; k <= 8; k++)
      tbl.push_back(v(0, 0, 0, 1, 64'(k), 1, 1, 1, 64'(k - 1), 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  1, 1, 1, 64'h8,  1, 0));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  0, 1, 0, 64'h8,  0, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'hA,  0, 1, 0, 64'h8,  0, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'hB,  0, 1, 1, 64'hA,  1, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'hC,  0, 0, 1, 64'hA,  2, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'hC,  1, 0, 1, 64'hA,  2, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'hC,  1, 1, 1, 64'hB,  1, 0));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  1, 1, 1, 64'hC,  1, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'h21, 0, 1, 0, 64'hC,  0, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'h22, 0, 1, 1, 64'h21, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 64'hFF, 0, 0, 1, 64'h21, 2, 0));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  0, 1, 0, BUB,    0, 0));
    tbl.push_back(v(0, 0, 0, 1, 64'h55, 0, 1, 0, BUB,    0, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(v(0, 0, 1, 1, 64'h66, 1, 0, 0, 64'h55, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  1, 1, 1, 64'h55, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  0, 1, 0, 64'h55, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 64'h0,  1, 0, 0, 64'h55, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  1, 1, 0, 64'h55, 0, 0));
    tbl.push_back(v(0, 1, 0, 0, 64'h0,  1, 0, 0, 64'h55, 0, 1));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  0, 1, 0, BUB,    0, 1));
    tbl.push_back(v(0, 0, 0, 1, 64'h77, 0, 1, 0, BUB,    0, 1));
    tbl.push_back(v(1, 0, 0, 1, 64'h88, 1, 0, 0, 64'h77, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 64'h0,  0, 1, 0, BUB,    0, 0));

    drive(1, 0, 0, 0, 64'h0, 0);
    cycle();
    model_en = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].hd, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #1;
      check($sformatf("vec%0d.in_ready", i),   64'(ir1),  64'(tbl[i].e_ir));
      check($sformatf("vec%0d.out_valid", i),  64'(ov1),  64'(tbl[i].e_ov));
      check($sformatf("vec%0d.out_data", i),   od1,       tbl[i].e_od);
      check($sformatf("vec%0d.occupancy", i),  64'(occ1), 64'(tbl[i].e_occ));
      check($sformatf("vec%0d.starve_cnt", i), 64'(cnt1), 64'(tbl[i].e_cnt));
      cycle();
    end

    // Single-register mode: in_ready follows out_ready within the cycle.
    drive(1, 0, 0, 0, 64'h0, 0);
    cycle();
    drive(0, 0, 0, 1, 64'h31, 0);
    cycle();
    drive(0, 0, 0, 0, 64'h0, 0);
    #1;
    check("comb.ready_low",  64'(ir0), 64'(0));
    check("comb.skid_ready", 64'(ir1), 64'(1));
    out_ready = 1'b1;
    #1;
    check("comb.ready_high",  64'(ir0), 64'(1));
    check("comb.skid_ready2", 64'(ir1), 64'(1));
    for (int k = 2; k <= 5; k++) begin
      drive(0, 0, 0, (k <= 4), 64'(32'h30 + k), 1);
      #1;
      check($sformatf("comb.data%0d", k),  od0,      64'(32'h30 + k - 1));
      check($sformatf("comb.valid%0d", k), 64'(ov0), 64'(1));
      cycle();
    end

    // Starvation counter saturation at 7, then a mid-run reset.
    drive(1, 0, 0, 0, 64'h0, 1);
    cycle();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 64'h0, 1);
      #1;
      check($sformatf("sat.cnt%0d", i), 64'(cnts), 64'((i < 7) ? i : 7));
      cycle();
    end
    drive(1, 0, 0, 0, 64'h0, 1);
    cycle();
    drive(0, 0, 0, 0, 64'h0, 1);
    #1;
    check("sat.cnt_after_reset",  64'(cnts), 64'(0));
    check("sat.valid_after_reset", 64'(ovs), 64'(0));
    check("sat.data_after_reset",  ods,      BUB);
    check("sat.occ_after_reset",   64'(occs), 64'(0));
    cycle();

    // Randomised traffic against the FIFO model.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
            {$urandom, $urandom}, ($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
